// File: rtl/rns_to_binary_pkg.sv
// Shared constants for the RNS reverse converter: moduli set, CRT weights and
// the FSM state encoding. Default set m = {13, 11, 7, 5} (index 0..3), M = 5005.
package rns_to_binary_pkg;

    localparam int NUM_MOD = 4;
    localparam int SWIDTH  = 16;
    localparam int LWIDTH  = 64;
    localparam int IDX_W   = $clog2(NUM_MOD);

    typedef logic [SWIDTH-1:0] res_t;
    typedef logic [LWIDTH-1:0] big_t;

    // m_i, M_i = M / m_i, y_i = M_i^-1 mod m_i, all indexed 0..NUM_MOD-1
    localparam res_t MODS   [NUM_MOD] = '{res_t'(13), res_t'(11), res_t'(7), res_t'(5)};
    localparam big_t BIG_M  [NUM_MOD] = '{big_t'(385), big_t'(455), big_t'(715), big_t'(1001)};
    localparam res_t INV_Y  [NUM_MOD] = '{res_t'(5), res_t'(3), res_t'(1), res_t'(1)};
    localparam big_t M_TOT            = big_t'(5005);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rns_to_binary_mod_mul.sv
// Registered modular multiply: p <= (a * b) mod m, one cycle latency, loads only on en.
module rns_mod_mul
    import rns_to_binary_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [SWIDTH-1:0] a,
    input  logic [SWIDTH-1:0] b,
    input  logic [SWIDTH-1:0] m,
    output logic [SWIDTH-1:0] p
);

    logic [2*SWIDTH-1:0] prod;
    logic [2*SWIDTH-1:0] rem;

    assign prod = a * b;
    assign rem  = prod % {{SWIDTH{1'b0}}, m};

    // Hold the reduced product so the accumulate step sees a stable operand
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  p <= '0;
        else if (en) p <= rem[SWIDTH-1:0];
    end

endmodule

// File: rtl/rns_to_binary.sv
// CRT reverse converter: X = sum_i(((r_i * y_i) mod m_i) * M_i) mod M, one
// residue per MUL/ACC pair. Accepts only in IDLE, holds the result in DONE.
module rns_to_binary
    import rns_to_binary_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_MOD*SWIDTH-1:0] residues,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LWIDTH-1:0]         x_out
);

    state_t                          state, state_nxt;
    logic [IDX_W-1:0]                idx;
    logic [LWIDTH-1:0]               acc;
    logic [NUM_MOD-1:0][SWIDTH-1:0]  res_q;
    logic [SWIDTH-1:0]               t;
    logic [LWIDTH-1:0]               sum;
    logic [LWIDTH-1:0]               sum_red;
    logic                            accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign x_out     = acc;
    assign accept    = in_ready && in_valid;

    // t = (r_idx * y_idx) mod m_idx, captured during MUL
    rns_mod_mul u_mul (
        .clk   (clk),
        .reset (reset),
        .en    (state == MUL),
        .a     (res_q[idx]),
        .b     (INV_Y[idx]),
        .m     (MODS[idx]),
        .p     (t)
    );

    // t < m_idx keeps t*M_idx < M, so acc + t*M_idx < 2M needs one subtract
    assign sum     = acc + LWIDTH'(t) * BIG_M[idx];
    assign sum_red = (sum >= M_TOT) ? sum - M_TOT : sum;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: one MUL/ACC pair per residue, DONE waits for out_ready
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid)        state_nxt = MUL;
            MUL:                       state_nxt = ACC;
            ACC:  if (idx == IDX_LAST) state_nxt = DONE;
                  else                 state_nxt = MUL;
            DONE: if (out_ready)       state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Datapath: residues latch only on the IDLE handshake, acc/idx advance in ACC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q <= '0;
            acc   <= '0;
            idx   <= '0;
        end else if (accept) begin
            res_q <= residues;
            acc   <= '0;
            idx   <= '0;
        end else if (state == ACC) begin
            acc <= sum_red;
            if (idx != IDX_LAST) idx <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_rns_to_binary.sv
// Bench for rns_to_binary: directed CRT vectors, backpressure, reset abort and
// a random back-to-back run, all scored against an exhaustive-search model.
module tb_rns_to_binary;

    localparam int NM = 4;
    localparam int SW = 16;
    localparam int MT = 5005;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [NM*SW-1:0] residues;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      x_out;

    int mods [NM] = '{13, 11, 7, 5};
    longint exp_q[$];
    int n_checks = 0;
    int n_err    = 0;

    rns_to_binary dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .residues  (residues),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NM*SW-1:0] pack4(input int r0, input int r1, input int r2, input int r3);
        logic [NM*SW-1:0] v;
        v = {SW'(r3), SW'(r2), SW'(r1), SW'(r0)};
        return v;
    endfunction

    // Model: the unique x in [0, M) congruent to every residue, found by search
    function automatic longint ref_x(input logic [NM*SW-1:0] v);
        bit ok;
        for (int x = 0; x < MT; x++) begin
            ok = 1'b1;
            for (int i = 0; i < NM; i++)
                if ((x % mods[i]) != (int'(v[i*SW +: SW]) % mods[i])) ok = 1'b0;
            if (ok) return longint'(x);
        end
        return -1;
    endfunction

    // Stimulus: residues of x, sometimes shifted up by one modulus (non-canonical)
    function automatic logic [NM*SW-1:0] res_of(input int x);
        logic [NM*SW-1:0] v;
        int r;
        v = '0;
        for (int i = 0; i < NM; i++) begin
            r = x % mods[i];
            if ($urandom_range(0, 3) == 0) r += mods[i];
            v[i*SW +: SW] = SW'(r);
        end
        return v;
    endfunction

    // Scoreboard: queue expectations on accept, check every valid output cycle
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                chk("ready_while_valid", longint'(in_ready), 0);
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    chk("x_out_vs_model", longint'(x_out), exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_x(residues));
        end
    end

    // Present a vector and hold it until the accept edge; leaves time at edge+1
    task automatic push_vec(input logic [NM*SW-1:0] v);
        int g;
        g = 0;
        residues = v;
        in_valid = 1'b1;
        while (!in_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) chk("accept_timeout", g, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        residues = {$urandom, $urandom};
    endtask

    // Counts edges from the accept edge (edge 1) until out_valid is seen
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", n, 0);
    endtask

    task automatic run_one(input string name, input logic [NM*SW-1:0] v, input longint exp);
        int n;
        push_vec(v);
        wait_out(n);
        chk(name, longint'(x_out), exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int seen;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        residues  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready",  longint'(in_ready),  1);
        chk("rst_x_out",     longint'(x_out),     0);
        reset = 1'b1;
        @(posedge clk); #1;

        // pin the model against hand-computed CRT values
        chk("model_29",   ref_x(pack4(3, 7, 1, 4)),    29);
        chk("model_5004", ref_x(pack4(12, 10, 6, 4)),  5004);
        chk("model_1234", ref_x(pack4(12, 2, 2, 4)),   1234);
        chk("model_nc",   ref_x(pack4(16, 7, 1, 4)),   29);

        // X=29 with latency measured from the accept edge
        push_vec(pack4(3, 7, 1, 4));
        wait_out(n);
        chk("latency", n, 9);
        chk("x29", longint'(x_out), 29);
        @(posedge clk); #1;
        chk("idle_after_29", longint'(in_ready), 1);

        run_one("x0",    pack4(0, 0, 0, 0),    0);
        run_one("x5004", pack4(12, 10, 6, 4),  5004);
        run_one("x_nc",  pack4(16, 7, 1, 4),   29);

        // backpressure: result held, in_valid during DONE ignored
        out_ready = 1'b0;
        push_vec(pack4(12, 2, 2, 4));
        wait_out(n);
        in_valid = 1'b1;
        residues = pack4(9, 1, 2, 0);
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_x",     longint'(x_out),     1234);
            chk("hold_ready", longint'(in_ready),  0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_ready", longint'(in_ready),  1);
        chk("release_valid", longint'(out_valid), 0);

        // reset during the third ACC of X=29 abandons the conversion
        push_vec(pack4(3, 7, 1, 4));
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_valid", longint'(out_valid), 0);
        chk("abort_ready", longint'(in_ready),  1);
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("no_result_after_abort", seen, 0);
        run_one("x100", pack4(9, 1, 2, 0), 100);

        // random back-to-back with random downstream stalls
        fork
            begin
                for (int k = 0; k < 1000; k++)
                    push_vec(res_of(int'($urandom_range(0, MT - 1))));
            end
            begin
                for (int k = 0; k < 14000; k++) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join_any
        disable fork;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
